// File: rtl/tower_game_pkg.sv
// Shared definitions for the tower stage: game FSM states, screen geometry
// and the tower sprite size used by both the tower mover and the hit logic.
package tower_game_pkg;

   typedef enum logic [1:0] {
      PLAY,
      HIT_PAUSE,
      GAME_OVER
   } game_state_t;

   localparam int SCREEN_WIDTH   = 640;
   localparam int SCREEN_HEIGHT  = 480;

   // Tower sprite dimensions, kept in one place so mover and hit box agree
   localparam int TOWER_WIDTH_X  = 28;
   localparam int TOWER_HEIGHT_Y = 58;

   localparam int OVERLAP_W      = 8;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [OVERLAP_W-1:0] sat_inc(input logic [OVERLAP_W-1:0] v);
      return (v == {OVERLAP_W{1'b1}}) ? v : v + OVERLAP_W'(1);
   endfunction

endpackage

// File: rtl/hitbox_overlap_counter.sv
// Counts player/tower coincident pixels that fall inside the tower's opaque
// hit box during one frame. The count saturates, restarts on startOfFrame
// (a pixel on that same cycle already belongs to the new frame), can be held
// while the game is over and cleared on a game restart.
module hitbox_overlap_counter
   import tower_game_pkg::*;
#(
   parameter int OBJECT_WIDTH_X = TOWER_WIDTH_X,
   parameter int OBJECT_HEIGHT_Y = TOWER_HEIGHT_Y,
   parameter int MARGIN_X = 4,
   parameter int MARGIN_Y = 6
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 clear,
   input  logic                 hold,
   input  logic                 startOfFrame,
   input  logic                 towerDrawingRequest,
   input  logic [10:0]          offsetX,
   input  logic [10:0]          offsetY,
   input  logic                 playerDrawingRequest,
   output logic [OVERLAP_W-1:0] frameOverlap
);

   localparam logic [10:0] X_LO = 11'(MARGIN_X);
   localparam logic [10:0] X_HI = 11'(OBJECT_WIDTH_X - MARGIN_X);
   localparam logic [10:0] Y_LO = 11'(MARGIN_Y);
   localparam logic [10:0] Y_HI = 11'(OBJECT_HEIGHT_Y - MARGIN_Y);

   logic                 hitPixel;
   logic [OVERLAP_W-1:0] overlapCnt_reg;

   // Pixel counts only when both sprites draw it and it is off the transparent border
   always_comb begin
      hitPixel = towerDrawingRequest && playerDrawingRequest &&
                 (offsetX >= X_LO) && (offsetX < X_HI) &&
                 (offsetY >= Y_LO) && (offsetY < Y_HI);
   end

   // Per-frame saturating overlap counter
   always_ff @(posedge clk) begin
      if (!resetN) begin
         overlapCnt_reg <= '0;
      end else if (clear) begin
         overlapCnt_reg <= '0;
      end else if (hold) begin
         overlapCnt_reg <= overlapCnt_reg;
      end else if (startOfFrame) begin
         overlapCnt_reg <= hitPixel ? OVERLAP_W'(1) : '0;
      end else if (hitPixel) begin
         overlapCnt_reg <= sat_inc(overlapCnt_reg);
      end
   end

   assign frameOverlap = overlapCnt_reg;

endmodule

// File: rtl/tower_hit_ctrl.sv
// Player/tower collision controller. Evaluates the overlap of the frame that
// just ended on every startOfFrame and runs the lives / hit-pause / game-over
// state machine, plus the level timer that raises the active tower count.
// Every output is a register, so the tower mover sees a new pause value one
// frame after the frame that caused it.
module tower_hit_ctrl
   import tower_game_pkg::*;
#(
   parameter int OBJECT_WIDTH_X  = TOWER_WIDTH_X,
   parameter int OBJECT_HEIGHT_Y = TOWER_HEIGHT_Y,
   parameter int MARGIN_X        = 4,
   parameter int MARGIN_Y        = 6,
   parameter int HIT_THRESHOLD   = 8,
   parameter int PAUSE_FRAMES    = 60,
   parameter int INIT_LIVES      = 3,
   parameter int LEVEL_FRAMES    = 600,
   parameter int INIT_TREES      = 1,
   parameter int MAX_TREES       = 15
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        towerDrawingRequest,
   input  logic [10:0] offsetX,
   input  logic [10:0] offsetY,
   input  logic        playerDrawingRequest,
   input  logic        restart,
   output logic        pause,
   output logic [3:0]  curTreeCount,
   output logic [2:0]  livesLeft,
   output logic        hitPulse,
   output logic        gameOver
);

   localparam int PCNT_W = $clog2(PAUSE_FRAMES + 1);
   localparam int LVL_W  = $clog2(LEVEL_FRAMES + 1);

   localparam logic [OVERLAP_W-1:0] HIT_TH     = OVERLAP_W'(HIT_THRESHOLD);
   localparam logic [PCNT_W-1:0]    PAUSE_LAST = PCNT_W'(PAUSE_FRAMES - 1);
   localparam logic [LVL_W-1:0]     LEVEL_LAST = LVL_W'(LEVEL_FRAMES - 1);
   localparam logic [2:0]           LIVES_INIT = 3'(INIT_LIVES);
   localparam logic [3:0]           TREES_INIT = 4'(INIT_TREES);
   localparam logic [3:0]           TREES_MAX  = 4'(MAX_TREES);

   game_state_t          state_reg, state_next;
   logic                 pause_reg, pause_next;
   logic                 gameOver_reg, gameOver_next;
   logic                 hitPulse_reg, hitPulse_next;
   logic [2:0]           livesLeft_reg, livesLeft_next;
   logic [3:0]           curTreeCount_reg, curTreeCount_next;
   logic [PCNT_W-1:0]    pauseCnt_reg, pauseCnt_next;
   logic [LVL_W-1:0]     levelCnt_reg, levelCnt_next;
   logic [OVERLAP_W-1:0] frameOverlap;
   logic                 overlapClear;
   logic                 overlapHold;

   // A restart wipes the partial frame; otherwise the counter freezes in GAME_OVER
   assign overlapClear = (state_reg == GAME_OVER) && restart;
   assign overlapHold  = (state_reg == GAME_OVER);

   hitbox_overlap_counter #(
      .OBJECT_WIDTH_X  (OBJECT_WIDTH_X),
      .OBJECT_HEIGHT_Y (OBJECT_HEIGHT_Y),
      .MARGIN_X        (MARGIN_X),
      .MARGIN_Y        (MARGIN_Y)
   ) u_overlap (
      .clk                  (clk),
      .resetN               (resetN),
      .clear                (overlapClear),
      .hold                 (overlapHold),
      .startOfFrame         (startOfFrame),
      .towerDrawingRequest  (towerDrawingRequest),
      .offsetX              (offsetX),
      .offsetY              (offsetY),
      .playerDrawingRequest (playerDrawingRequest),
      .frameOverlap         (frameOverlap)
   );

   // State, counters and all outputs register here
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_reg        <= PLAY;
         pause_reg        <= 1'b0;
         gameOver_reg     <= 1'b0;
         hitPulse_reg     <= 1'b0;
         livesLeft_reg    <= LIVES_INIT;
         curTreeCount_reg <= TREES_INIT;
         pauseCnt_reg     <= '0;
         levelCnt_reg     <= '0;
      end else begin
         state_reg        <= state_next;
         pause_reg        <= pause_next;
         gameOver_reg     <= gameOver_next;
         hitPulse_reg     <= hitPulse_next;
         livesLeft_reg    <= livesLeft_next;
         curTreeCount_reg <= curTreeCount_next;
         pauseCnt_reg     <= pauseCnt_next;
         levelCnt_reg     <= levelCnt_next;
      end
   end

   // Next-state and next-output logic; frames are judged only on startOfFrame
   always_comb begin
      state_next        = state_reg;
      pause_next        = pause_reg;
      gameOver_next     = gameOver_reg;
      hitPulse_next     = 1'b0;
      livesLeft_next    = livesLeft_reg;
      curTreeCount_next = curTreeCount_reg;
      pauseCnt_next     = pauseCnt_reg;
      levelCnt_next     = levelCnt_reg;

      case (state_reg)
         PLAY: begin
            if (startOfFrame) begin
               if (frameOverlap >= HIT_TH) begin
                  hitPulse_next  = 1'b1;
                  livesLeft_next = livesLeft_reg - 3'd1;
                  pause_next     = 1'b1;
                  if (livesLeft_reg == 3'd1) begin
                     state_next    = GAME_OVER;
                     gameOver_next = 1'b1;
                  end else begin
                     state_next    = HIT_PAUSE;
                     pauseCnt_next = PAUSE_LAST;
                  end
               end else if (levelCnt_reg == LEVEL_LAST) begin
                  levelCnt_next = '0;
                  if (curTreeCount_reg < TREES_MAX) begin
                     curTreeCount_next = curTreeCount_reg + 4'd1;
                  end
               end else begin
                  levelCnt_next = levelCnt_reg + LVL_W'(1);
               end
            end
         end

         HIT_PAUSE: begin
            if (startOfFrame) begin
               if (pauseCnt_reg == '0) begin
                  state_next = PLAY;
                  pause_next = 1'b0;
               end else begin
                  pauseCnt_next = pauseCnt_reg - PCNT_W'(1);
               end
            end
         end

         GAME_OVER: begin
            if (restart) begin
               state_next        = PLAY;
               pause_next        = 1'b0;
               gameOver_next     = 1'b0;
               livesLeft_next    = LIVES_INIT;
               curTreeCount_next = TREES_INIT;
               levelCnt_next     = '0;
               pauseCnt_next     = '0;
            end
         end

         default: begin
            state_next = PLAY;
         end
      endcase
   end

   assign pause        = pause_reg;
   assign gameOver     = gameOver_reg;
   assign hitPulse     = hitPulse_reg;
   assign livesLeft    = livesLeft_reg;
   assign curTreeCount = curTreeCount_reg;

endmodule

// File: tb/tb_tower_hit_ctrl.sv
// Self-checking bench for tower_hit_ctrl. A frame-level model (lives, trees,
// frames of pause left, frames played since the last level-up) tracks the
// expected outputs; every clock cycle compares all outputs against it.
module tb_tower_hit_ctrl;

   logic        clk = 1'b0;
   logic        resetN;
   logic        startOfFrame;
   logic        towerDrawingRequest;
   logic [10:0] offsetX;
   logic [10:0] offsetY;
   logic        playerDrawingRequest;
   logic        restart;
   logic        pause;
   logic [3:0]  curTreeCount;
   logic [2:0]  livesLeft;
   logic        hitPulse;
   logic        gameOver;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   int m_lives, m_trees, m_played, m_pause_left, m_cnt;
   bit m_over, m_hit;

   always #5 clk = ~clk;

   tower_hit_ctrl dut (
      .clk                  (clk),
      .resetN               (resetN),
      .startOfFrame         (startOfFrame),
      .towerDrawingRequest  (towerDrawingRequest),
      .offsetX              (offsetX),
      .offsetY              (offsetY),
      .playerDrawingRequest (playerDrawingRequest),
      .restart              (restart),
      .pause                (pause),
      .curTreeCount         (curTreeCount),
      .livesLeft            (livesLeft),
      .hitPulse             (hitPulse),
      .gameOver             (gameOver)
   );

   task automatic model_init();
      m_lives = 3; m_trees = 1; m_played = 0; m_pause_left = 0;
      m_cnt = 0; m_over = 0; m_hit = 0;
   endtask

   // Judge one finished frame the way the game rules describe it
   task automatic model_frame_end();
      if (m_pause_left > 0) begin
         m_pause_left--;
      end else if (m_cnt >= 8) begin
         m_lives--;
         m_hit = 1;
         if (m_lives == 0) m_over = 1;
         else m_pause_left = 60;
      end else begin
         m_played++;
         if (m_played == 600) begin
            m_played = 0;
            if (m_trees < 15) m_trees++;
         end
      end
   endtask

   // One clock cycle of stimulus, model update and full output comparison
   task automatic tick(input bit sof, input bit tdr, input bit pdr,
                       input int ox, input int oy, input bit rst, input bit rs);
      bit inbox;
      bit e_pause;
      startOfFrame = sof;
      towerDrawingRequest = tdr;
      playerDrawingRequest = pdr;
      offsetX = ox[10:0];
      offsetY = oy[10:0];
      resetN = !rst;
      restart = rs;
      inbox = tdr && pdr && ox >= 4 && ox < 28 - 4 && oy >= 6 && oy < 58 - 6;
      @(posedge clk);
      m_hit = 0;
      if (rst) begin
         model_init();
      end else if (m_over) begin
         if (rs) begin
            m_lives = 3; m_trees = 1; m_played = 0; m_pause_left = 0;
            m_cnt = 0; m_over = 0;
         end
      end else if (sof) begin
         model_frame_end();
         m_cnt = inbox ? 1 : 0;
      end else if (inbox && m_cnt < 255) begin
         m_cnt++;
      end
      #1;
      e_pause = m_over || (m_pause_left > 0);
      n_checks++;
      if (pause !== e_pause) begin
         n_fail++;
         $display("FAIL pause at %0t: got %b expected %b", $time, pause, e_pause);
      end
      n_checks++;
      if (gameOver !== m_over) begin
         n_fail++;
         $display("FAIL gameOver at %0t: got %b expected %b", $time, gameOver, m_over);
      end
      n_checks++;
      if (livesLeft !== 3'(m_lives)) begin
         n_fail++;
         $display("FAIL livesLeft at %0t: got %0d expected %0d", $time, livesLeft, m_lives);
      end
      n_checks++;
      if (curTreeCount !== 4'(m_trees)) begin
         n_fail++;
         $display("FAIL curTreeCount at %0t: got %0d expected %0d", $time, curTreeCount, m_trees);
      end
      n_checks++;
      if (hitPulse !== m_hit) begin
         n_fail++;
         $display("FAIL hitPulse at %0t: got %b expected %b", $time, hitPulse, m_hit);
      end
      n_checks++;
      if (dut.frameOverlap !== 8'(m_cnt)) begin
         n_fail++;
         $display("FAIL overlapCnt at %0t: got %0d expected %0d", $time, dut.frameOverlap, m_cnt);
      end
   endtask

   // Frame of npix coincident pixels at (ox,oy), one idle pixel, then startOfFrame
   task automatic run_frame(input int npix, input int ox, input int oy);
      for (int i = 0; i < npix; i++) tick(0, 1, 1, ox, oy, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wait_pause();
      for (int i = 0; i < 60; i++) run_frame(0, 0, 0);
   endtask

   task automatic test_reset();
      model_init();
      tick(0, 0, 0, 0, 0, 1, 0);
      tick(0, 0, 0, 0, 0, 1, 0);
      n_checks++;
      if (pause !== 1'b0 || gameOver !== 1'b0 || hitPulse !== 1'b0 ||
          livesLeft !== 3'd3 || curTreeCount !== 4'd1) begin
         n_fail++;
         $display("FAIL reset_values: got p=%b go=%b hp=%b lives=%0d trees=%0d expected 0 0 0 3 1",
                  pause, gameOver, hitPulse, livesLeft, curTreeCount);
      end
      $display("test_reset done");
   endtask

   task automatic test_level();
      for (int f = 1; f <= 600; f++) begin
         run_frame(0, 0, 0);
         if (f == 599) begin
            n_checks++;
            if (curTreeCount !== 4'd1) begin
               n_fail++;
               $display("FAIL level_early: got %0d expected 1", curTreeCount);
            end
         end
      end
      n_checks++;
      if (curTreeCount !== 4'd2 || livesLeft !== 3'd3 || pause !== 1'b0) begin
         n_fail++;
         $display("FAIL level_up: got trees=%0d lives=%0d pause=%b expected 2 3 0",
                  curTreeCount, livesLeft, pause);
      end
      $display("test_level done trees=%0d", curTreeCount);
   endtask

   task automatic test_hit();
      run_frame(8, 10, 20);
      n_checks++;
      if (hitPulse !== 1'b1 || livesLeft !== 3'd2 || pause !== 1'b1) begin
         n_fail++;
         $display("FAIL hit: got hp=%b lives=%0d pause=%b expected 1 2 1", hitPulse, livesLeft, pause);
      end
      tick(0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (hitPulse !== 1'b0) begin
         n_fail++;
         $display("FAIL hit_width: got %b expected 0", hitPulse);
      end
      for (int f = 1; f <= 60; f++) begin
         run_frame(0, 0, 0);
         if (f == 59) begin
            n_checks++;
            if (pause !== 1'b1) begin
               n_fail++;
               $display("FAIL pause_hold: got %b expected 1", pause);
            end
         end
      end
      n_checks++;
      if (pause !== 1'b0) begin
         n_fail++;
         $display("FAIL pause_release: got %b expected 0", pause);
      end
      $display("test_hit done lives=%0d", livesLeft);
   endtask

   task automatic test_no_hit();
      run_frame(7, 10, 20);
      run_frame(50, 2, 20);
      n_checks++;
      if (livesLeft !== 3'd2 || pause !== 1'b0) begin
         n_fail++;
         $display("FAIL no_hit: got lives=%0d pause=%b expected 2 0", livesLeft, pause);
      end
      $display("test_no_hit done");
   endtask

   task automatic test_game_over();
      for (int k = 0; k < 5 && !m_over; k++) begin
         run_frame(8, 10, 20);
         if (!m_over) wait_pause();
      end
      n_checks++;
      if (livesLeft !== 3'd0 || gameOver !== 1'b1 || pause !== 1'b1) begin
         n_fail++;
         $display("FAIL game_over: got lives=%0d go=%b pause=%b expected 0 1 1", livesLeft, gameOver, pause);
      end
      for (int k = 0; k < 3; k++) run_frame(20, 12, 30);
      tick(0, 0, 0, 0, 0, 0, 1);
      n_checks++;
      if (livesLeft !== 3'd3 || curTreeCount !== 4'd1 || gameOver !== 1'b0 || pause !== 1'b0) begin
         n_fail++;
         $display("FAIL restart: got lives=%0d trees=%0d go=%b pause=%b expected 3 1 0 0",
                  livesLeft, curTreeCount, gameOver, pause);
      end
      $display("test_game_over done");
   endtask

   task automatic test_pause_hits();
      int pulses;
      pulses = 0;
      run_frame(10, 10, 20);
      for (int f = 0; f < 60; f++) begin
         for (int i = 0; i < 12; i++) begin
            tick(0, 1, 1, 10, 20, 0, 0);
            if (hitPulse === 1'b1) pulses++;
         end
         tick(1, 0, 0, 0, 0, 0, 0);
         if (hitPulse === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses != 0 || livesLeft !== 3'd2) begin
         n_fail++;
         $display("FAIL pause_hits: got pulses=%0d lives=%0d expected 0 2", pulses, livesLeft);
      end
      for (int f = 0; f < 300; f++) run_frame(1, 14, 29);
      n_checks++;
      if (livesLeft !== 3'd2) begin
         n_fail++;
         $display("FAIL single_pixel_frames: got lives=%0d expected 2", livesLeft);
      end
      $display("test_pause_hits done");
   endtask

   task automatic test_reset_mid_pause();
      run_frame(8, 10, 20);
      for (int i = 0; i < 5; i++) tick(0, 1, 1, 10, 20, 0, 0);
      n_checks++;
      if (dut.frameOverlap !== 8'd5 || pause !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset: got cnt=%0d pause=%b expected 5 1", dut.frameOverlap, pause);
      end
      tick(0, 1, 1, 10, 20, 1, 0);
      n_checks++;
      if (pause !== 1'b0 || livesLeft !== 3'd3 || curTreeCount !== 4'd1 ||
          gameOver !== 1'b0 || hitPulse !== 1'b0 || dut.frameOverlap !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_mid_pause: got p=%b lives=%0d trees=%0d go=%b hp=%b cnt=%0d expected 0 3 1 0 0 0",
                  pause, livesLeft, curTreeCount, gameOver, hitPulse, dut.frameOverlap);
      end
      $display("test_reset_mid_pause done");
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) tick(0, 1, 1, 14, 29, 0, 0);
      n_checks++;
      if (dut.frameOverlap !== 8'd255) begin
         n_fail++;
         $display("FAIL saturation: got %0d expected 255", dut.frameOverlap);
      end
      tick(1, 1, 1, 14, 29, 0, 0);
      n_checks++;
      if (hitPulse !== 1'b1 || dut.frameOverlap !== 8'd1) begin
         n_fail++;
         $display("FAIL sat_hit: got hp=%b cnt=%0d expected 1 1", hitPulse, dut.frameOverlap);
      end
      wait_pause();
      $display("test_saturation done lives=%0d", livesLeft);
   endtask

   task automatic test_margins();
      // Just-outside edges only: no hit
      for (int i = 0; i < 10; i++) begin
         tick(0, 1, 1, 3, 20, 0, 0);
         tick(0, 1, 1, 24, 20, 0, 0);
         tick(0, 1, 1, 10, 5, 0, 0);
         tick(0, 1, 1, 10, 52, 0, 0);
      end
      tick(1, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (hitPulse !== 1'b0) begin
         n_fail++;
         $display("FAIL margin_outside: got %b expected 0", hitPulse);
      end
      // Just-inside corners: exactly threshold, hit
      for (int i = 0; i < 4; i++) begin
         tick(0, 1, 1, 4, 6, 0, 0);
         tick(0, 1, 1, 23, 51, 0, 0);
      end
      tick(1, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (hitPulse !== 1'b1) begin
         n_fail++;
         $display("FAIL margin_inside: got %b expected 1", hitPulse);
      end
      wait_pause();
      $display("test_margins done lives=%0d", livesLeft);
   endtask

   task automatic test_random();
      for (int f = 0; f < 250; f++) begin
         int npix;
         npix = $urandom_range(0, 14);
         for (int i = 0; i < npix; i++) begin
            tick(0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
                 $urandom_range(0, 30), $urandom_range(0, 60), 0,
                 ($urandom_range(0, 15) == 0));
         end
         tick(1, 1, ($urandom_range(0, 1) == 1), $urandom_range(0, 27), $urandom_range(0, 57), 0, 0);
      end
      $display("test_random done lives=%0d trees=%0d", livesLeft, curTreeCount);
   endtask

   initial begin
      resetN = 1'b0;
      startOfFrame = 1'b0;
      towerDrawingRequest = 1'b0;
      playerDrawingRequest = 1'b0;
      offsetX = '0;
      offsetY = '0;
      restart = 1'b0;
      test_reset();
      test_level();
      test_hit();
      test_no_hit();
      test_game_over();
      test_pause_hits();
      test_reset_mid_pause();
      test_saturation();
      test_margins();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tower_hit_ctrl.md
Name: tower_hit_ctrl

Overview:
Consumes the per-pixel tower drawing request and offsets, together with the player sprite's drawing request. Detects player/tower overlap per frame and runs the lives / hit-pause / game-over state machine. Drives the tower mover's pause and curTreeCount inputs, closing the loop around the tower stage. Sits between the object drawers and the game-control/mux logic.

Parameters:
OBJECT_WIDTH_X, 28, tower sprite width in pixels
OBJECT_HEIGHT_Y, 58, tower sprite height in pixels
MARGIN_X, 4, transparent horizontal margin excluded from hit box on each side
MARGIN_Y, 6, transparent vertical margin excluded from hit box on each side
HIT_THRESHOLD, 8, overlapping pixels per frame needed to register a hit
PAUSE_FRAMES, 60, frames the tower field is frozen after a hit
INIT_LIVES, 3, lives after reset/restart (1..7)
LEVEL_FRAMES, 600, PLAY frames between tree-count increments
INIT_TREES, 1, curTreeCount after reset/restart
MAX_TREES, 15, curTreeCount ceiling

Ports:
clk  in  1  system clock
resetN  in  1  synchronous active-low reset
startOfFrame  in  1  one-cycle pulse at frame start
towerDrawingRequest  in  1  tower pixel valid (registered, from tower mover)
offsetX  in  11  pixel offset inside tower, valid with towerDrawingRequest
offsetY  in  11  pixel offset inside tower
playerDrawingRequest  in  1  player pixel valid, aligned to the same pixel
restart  in  1  level-sensitive; restarts game from GAME_OVER
pause  out  1  freeze tower movement
curTreeCount  out  4  active tower count for tower mover
livesLeft  out  3  remaining lives
hitPulse  out  1  one-cycle pulse when a hit is registered
gameOver  out  1  high in GAME_OVER

Behaviour:
- Reset is sampled only on posedge clk when resetN=0. Reset values: state=PLAY, pause=0, curTreeCount=INIT_TREES, livesLeft=INIT_LIVES, hitPulse=0, gameOver=0, all counters 0.
- Hit-box pixel: towerDrawingRequest & playerDrawingRequest & MARGIN_X<=offsetX<OBJECT_WIDTH_X-MARGIN_X & MARGIN_Y<=offsetY<OBJECT_HEIGHT_Y-MARGIN_Y.
- overlapCnt: 8-bit, saturates at 255.
  - Increments on each hit-box pixel.
  - Cleared on startOfFrame. If a hit-box pixel coincides with startOfFrame, it loads 1 (the pixel belongs to the new frame).
- Frame evaluation happens on the startOfFrame cycle, using overlapCnt before the clear.
- FSM states:
  - PLAY: pause=0.
    - If overlapCnt>=HIT_THRESHOLD: hitPulse=1 next cycle, livesLeft-=1.
    - If the new livesLeft==0, go to GAME_OVER. Otherwise go to HIT_PAUSE with pauseCnt=PAUSE_FRAMES-1.
    - Otherwise levelCnt+=1. When levelCnt reaches LEVEL_FRAMES-1, levelCnt=0 and curTreeCount=min(curTreeCount+1, MAX_TREES).
  - HIT_PAUSE: pause=1; overlap is ignored (no hits). Each startOfFrame: if pauseCnt==0, go to PLAY; else pauseCnt-=1. levelCnt holds.
  - GAME_OVER: pause=1, gameOver=1; all counters hold. restart=1 on any clk cycle moves to PLAY with INIT_LIVES, INIT_TREES, levelCnt=0, overlapCnt=0.
- restart is ignored outside GAME_OVER.
- All outputs are registered. pause, gameOver and livesLeft change the cycle after the startOfFrame that triggered them, so the tower mover first sees pause at the next frame's update. This one-frame lag is required.
- hitPulse is exactly one cycle wide, at most once per frame.
- livesLeft never underflows. curTreeCount never exceeds MAX_TREES. No wrap on any counter.
- Reset asserted mid-frame or mid-pause fully restores the reset values on the next edge.

Decomposition:
- Package tower_game_pkg holds:
  - typedef enum {PLAY, HIT_PAUSE, GAME_OVER} game_state_t
  - screen constants 640/480
  - the tower sprite width/height constants, shared with the tower mover
- Sub-module hitbox_overlap_counter: combines the margin compare with the saturating per-frame counter and outputs frameOverlap at startOfFrame.
- FSM and level logic stay in the top module.

Test Plan:
- Reset, then 600 startOfFrame pulses with no player pixels -> curTreeCount 1->2 on the cycle after the 600th pulse; livesLeft=3, pause=0.
- 8 coincident pixels at offset (10,20) in one frame, then startOfFrame -> hitPulse one cycle, livesLeft=2, pause=1. pause drops to 0 after the 60th subsequent startOfFrame.
- 7 coincident pixels, or 50 coincident pixels at offsetX=2 (inside margin) -> no hit, livesLeft unchanged.
- Three hit frames, each separated by 60+ frames -> after the third: livesLeft=0, gameOver=1, pause=1. Further overlap has no effect; restart=1 -> PLAY, livesLeft=3, curTreeCount=1.
- Hits injected during HIT_PAUSE -> ignored, no hitPulse. 300 frames of 1 pixel at offset (14,29) -> counter saturation not triggered, no hit.
- resetN=0 for one cycle mid-HIT_PAUSE with overlapCnt=5 -> next cycle all outputs at reset values, overlapCnt=0.
